// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - segment patterns and shared types for the scan driver
package seg7_scan_driver_pkg;

  // Segment bit order is {dp,g,f,e,d,c,b,a}; patterns below cover g..a only.
  localparam int SEG_DP_BIT = 7;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef struct packed {
    logic       dp;
    logic [6:0] seg;
  } seg_word_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - digit source and display pin bundle for the scan driver
interface seg7_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blink_in;
  logic                lz_en;
  logic                load;
  logic [DIGITS-1:0]   seg_an;
  logic [7:0]          seg_out;
  logic                frame_done;

  modport master (
    output digits_in, dp_in, blink_in, lz_en, load,
    input  seg_an, seg_out, frame_done
  );

  modport slave (
    input  digits_in, dp_in, blink_in, lz_en, load,
    output seg_an, seg_out, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// rtl/seg7_scan_driver_bcd_to_seg7.sv - combinational BCD digit to 7-segment pattern
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Values 10-15 are not valid BCD and show a dash as an error marker.
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment driver with frame-synchronous digit shadow
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int DIGITS   = 8,
  parameter int GUARD    = 4,
  parameter int BLINK_HZ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int BHALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW    = (BHALF > 1) ? $clog2(BHALF) : 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [4*DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   act_bl_q, act_bl_d, pend_bl_q, pend_bl_d;
  logic                pend_v_q, pend_v_d;
  logic [DIGITS-1:0]   seg_an_q, seg_an_d;
  logic [7:0]          seg_out_q, seg_out_d;
  logic                fd_q, fd_d;

  logic                tick, boundary;
  logic [3:0]          cur_digit;
  logic                cur_dp, cur_bl, cur_blank;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   blank_vec;
  logic                zero_above;
  seg_word_t           word;

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Select the active digit for the current slot and work out leading-zero blanking.
  always_comb begin
    cur_digit  = 4'd0;
    cur_dp     = 1'b0;
    cur_bl     = 1'b0;
    cur_blank  = 1'b0;
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above && (act_dig_q[4*i +: 4] == 4'd0);
      blank_vec[i] = bus.lz_en && (i != 0) && zero_above;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_digit = act_dig_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_bl    = act_bl_q[i];
        cur_blank = blank_vec[i];
      end
    end
  end

  // Next-state for prescaler, slot index, blink phase, digit shadow and registered outputs.
  always_comb begin
    tick        = (cnt_q == CW'(DIV - 1));
    boundary    = tick && (idx_q == IW'(DIGITS - 1));
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_bl_d    = act_bl_q;
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    pend_bl_d   = pend_bl_q;
    pend_v_d    = pend_v_q;
    seg_an_d    = '0;
    seg_out_d   = 8'h00;
    fd_d        = boundary;
    word        = '0;

    if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    if (blink_cnt_q == BW'(BHALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    // A load on the boundary bypasses pending so it appears in the very next frame.
    if (boundary) begin
      pend_v_d = 1'b0;
      if (bus.load) begin
        act_dig_d = bus.digits_in;
        act_dp_d  = bus.dp_in;
        act_bl_d  = bus.blink_in;
      end else if (pend_v_q) begin
        act_dig_d = pend_dig_q;
        act_dp_d  = pend_dp_q;
        act_bl_d  = pend_bl_q;
      end
    end else if (bus.load) begin
      pend_dig_d = bus.digits_in;
      pend_dp_d  = bus.dp_in;
      pend_bl_d  = bus.blink_in;
      pend_v_d   = 1'b1;
    end

    // Anodes stay off for the first GUARD clocks of each slot to avoid ghosting.
    if (cnt_q >= CW'(GUARD)) begin
      seg_an_d[idx_q] = 1'b1;
      word.dp         = cur_dp;
      word.seg        = cur_blank ? SEG_OFF : dec_seg;
      if (!phase_q && cur_bl) word = '0;
      seg_out_d       = word;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_bl_q    <= '0;
      pend_dig_q  <= '0;
      pend_dp_q   <= '0;
      pend_bl_q   <= '0;
      pend_v_q    <= 1'b0;
      seg_an_q    <= '0;
      seg_out_q   <= 8'h00;
      fd_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_bl_q    <= act_bl_d;
      pend_dig_q  <= pend_dig_d;
      pend_dp_q   <= pend_dp_d;
      pend_bl_q   <= pend_bl_d;
      pend_v_q    <= pend_v_d;
      seg_an_q    <= seg_an_d;
      seg_out_q   <= seg_out_d;
      fd_q        <= fd_d;
    end
  end

  assign bus.seg_an     = seg_an_q;
  assign bus.seg_out    = seg_out_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized and directed checks of seg7_scan_driver against a frame-level model
module tb_seg7_scan_driver;

  localparam int CLK_HZ   = 16;
  localparam int SCAN_HZ  = 4;
  localparam int NDIG     = 4;
  localparam int GUARD    = 1;
  localparam int BLINK_HZ = 1;
  localparam int DIV      = CLK_HZ / SCAN_HZ;
  localparam int BH       = CLK_HZ / (2 * BLINK_HZ);
  localparam int FRAME    = DIV * NDIG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(NDIG)) bus ();

  seg7_scan_driver #(
    .CLK_HZ   (CLK_HZ),
    .SCAN_HZ  (SCAN_HZ),
    .DIGITS   (NDIG),
    .GUARD    (GUARD),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  int n      = 0;

  logic [15:0] m_dig, p_dig;
  logic [3:0]  m_dp, m_bl, p_dp, p_bl;
  logic        p_v;

  int pat_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                       8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int idx, input logic [15:0] d, input logic [3:0] dp,
                                         input logic [3:0] bl, input logic lz, input logic ph);
    int v, upper;
    logic [7:0] r;
    v     = int'((d >> (4 * idx)) & 16'hF);
    upper = int'(d >> (4 * idx));
    r     = 8'(pat_tbl[v]);
    if (lz && idx != 0 && upper == 0) r = 8'h00;
    r[7] = dp[idx];
    if (!ph && bl[idx]) r = 8'h00;
    return r;
  endfunction

  task automatic model_reset();
    n = 0;
    m_dig = '0; m_dp = '0; m_bl = '0;
    p_dig = '0; p_dp = '0; p_bl = '0; p_v = 1'b0;
  endtask

  // One clock: predict from the time since reset release, then sample 1 time unit after the edge.
  task automatic cyc();
    int k, cnt, idx;
    logic ph, bnd;
    logic [3:0] ean;
    logic [7:0] eseg;
    k    = n;
    cnt  = k % DIV;
    idx  = (k / DIV) % NDIG;
    ph   = ((k / BH) % 2) == 0;
    bnd  = (k % FRAME) == FRAME - 1;
    ean  = (cnt < GUARD) ? 4'h0 : 4'(1 << idx);
    eseg = (cnt < GUARD) ? 8'h00 : exp_seg(idx, m_dig, m_dp, m_bl, bus.lz_en, ph);
    if (bnd) begin
      if (bus.load) begin
        m_dig = bus.digits_in; m_dp = bus.dp_in; m_bl = bus.blink_in;
      end else if (p_v) begin
        m_dig = p_dig; m_dp = p_dp; m_bl = p_bl;
      end
      p_v = 1'b0;
    end else if (bus.load) begin
      p_dig = bus.digits_in; p_dp = bus.dp_in; p_bl = bus.blink_in; p_v = 1'b1;
    end
    @(posedge clk);
    #1;
    n++;
    chk("seg_an", k, 32'(bus.seg_an), 32'(ean));
    chk("seg_out", k, 32'(bus.seg_out), 32'(eseg));
    chk("frame_done", k, 32'(bus.frame_done), 32'(bnd));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cyc();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    bus.digits_in = d;
    bus.dp_in     = dp;
    bus.blink_in  = bl;
    bus.load      = 1'b1;
    cyc();
    bus.load      = 1'b0;
  endtask

  task automatic goto_slot(input int slot, input int c);
    for (int i = 0; i < FRAME; i++) begin
      if ((n % DIV) == c && ((n / DIV) % NDIG) == slot) break;
      cyc();
    end
  endtask

  initial begin
    logic [15:0] rd;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    bus.blink_in  = '0;
    bus.lz_en     = 1'b0;
    bus.load      = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_seg_an", 0, 32'(bus.seg_an), 32'h0);
    chk("reset_seg_out", 0, 32'(bus.seg_out), 32'h0);
    chk("reset_frame_done", 0, 32'(bus.frame_done), 32'h0);
    #3 rst_n = 1'b1;

    run(2 * FRAME + 3);

    do_load(16'h0120, 4'h0, 4'h0);
    bus.lz_en = 1'b1;
    run(2 * FRAME);
    bus.lz_en = 1'b0;
    run(FRAME);

    goto_slot(1, 2);
    do_load(16'h1234, 4'h0, 4'h0);
    run(3);
    do_load(16'h5678, 4'h0, 4'h0);
    run(2 * FRAME);

    goto_slot(3, DIV - 1);
    do_load(16'h4321, 4'h2, 4'h0);
    run(FRAME + 4);

    do_load(16'h000B, 4'h1, 4'h0);
    run(2 * FRAME);
    do_load(16'h000B, 4'h1, 4'h1);
    run(4 * FRAME);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(19) == 0) bus.lz_en = 1'($urandom_range(1));
      if ($urandom_range(6) == 0) begin
        for (int j = 0; j < NDIG; j++)
          rd[4*j +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
        do_load(rd, 4'($urandom_range(15)), 4'($urandom_range(15)));
      end else begin
        cyc();
      end
    end

    bus.lz_en = 1'b0;
    goto_slot(2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg_an", n, 32'(bus.seg_an), 32'h0);
    chk("async_rst_seg_out", n, 32'(bus.seg_out), 32'h0);
    chk("async_rst_frame_done", n, 32'(bus.frame_done), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    run(FRAME + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
